// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder for a cache memory port
// FREE -> BUSY (LAT cycles) -> ACCESS (one cycle, dwait low) -> FREE.
module dmem_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 256
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic [1:0]  memstate
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10
  } state_t;

  localparam state_t FIRST = (LAT == 0) ? ACCESS : BUSY;
  localparam logic [3:0] LAT_CNT = LAT[3:0];

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [IW-1:0] idx_q, idx_nxt, req_idx;
  logic          wr_q, wr_nxt;
  logic          req_any, req_wr;
  logic [31:0]   dload_q;
  logic [31:0]   mem [DEPTH];
  logic          unused_addr_bits;

  assign req_idx          = daddr[IW+1:2];
  assign req_any          = dREN | dWEN;
  assign req_wr           = dWEN;
  assign unused_addr_bits = ^{daddr[31:IW+2], daddr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    wr_nxt    = wr_q;
    case (state)
      FREE: begin
        if (req_any) begin
          idx_nxt   = req_idx;
          wr_nxt    = req_wr;
          cnt_nxt   = LAT_CNT;
          state_nxt = FIRST;
        end
      end
      BUSY: begin
        // Any change to the held request abandons it; the new one starts over from FREE.
        if (!req_any || req_idx != idx_q || req_wr != wr_q) begin
          state_nxt = FREE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS:  state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FREE;
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      dload_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx_q <= idx_nxt;
      wr_q  <= wr_nxt;
      if (state == ACCESS && !wr_q) begin
        dload_q <= mem[idx_q];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ACCESS && wr_q) begin
      mem[idx_q] <= dstore;
    end
  end

  // Read data is presented combinationally in the completion cycle, then held.
  assign dload    = (state == ACCESS && !wr_q) ? mem[idx_q] : dload_q;
  assign dwait    = (state != ACCESS);
  assign memstate = state;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// Three instances: LAT=2 (table + reset), LAT=0 (aliasing), LAT=3 (withdraw).
module tb_dmem_responder;

  localparam logic [1:0] FR = 2'b00;
  localparam logic [1:0] BU = 2'b01;
  localparam logic [1:0] AC = 2'b10;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] A5 = 32'hA5A5_A5A5;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst2, rst_n;
  logic        ren2, wen2, ren0, wen0, ren3, wen3;
  logic [31:0] addr2, st2, addr0, st0, addr3, st3;
  logic        dwait2, dwait0, dwait3;
  logic [31:0] dload2, dload0, dload3;
  logic [1:0]  ms2, ms0, ms3;

  dmem_responder #(.LAT(2), .DEPTH(256)) u2 (
    .CLK(CLK), .nRST(rst2), .dREN(ren2), .dWEN(wen2), .daddr(addr2), .dstore(st2),
    .dwait(dwait2), .dload(dload2), .memstate(ms2));
  dmem_responder #(.LAT(0), .DEPTH(256)) u0 (
    .CLK(CLK), .nRST(rst_n), .dREN(ren0), .dWEN(wen0), .daddr(addr0), .dstore(st0),
    .dwait(dwait0), .dload(dload0), .memstate(ms0));
  dmem_responder #(.LAT(3), .DEPTH(256)) u3 (
    .CLK(CLK), .nRST(rst_n), .dREN(ren3), .dWEN(wen3), .daddr(addr3), .dstore(st3),
    .dwait(dwait3), .dload(dload3), .memstate(ms3));

  int total  = 0;
  int passed = 0;
  logic [31:0] sb [$];

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, store;
    logic        push;
    logic [31:0] rd;
    logic [1:0]  st;
    logic        dw;
    logic [31:0] dl;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input logic ren, input logic wen, input logic [31:0] addr,
                             input logic [31:0] store, input logic push, input logic [31:0] rd,
                             input logic [1:0] st, input logic dw, input logic [31:0] dl);
    vec_t r;
    r.ren = ren; r.wen = wen; r.addr = addr; r.store = store;
    r.push = push; r.rd = rd; r.st = st; r.dw = dw; r.dl = dl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive2(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] store);
    @(posedge CLK); #1;
    ren2 = ren; wen2 = wen; addr2 = addr; st2 = store;
  endtask

  // Scoreboard: every completed read on the LAT=2 instance pops one expected word.
  always @(negedge CLK) begin
    if (rst2 && !dwait2 && !wen2) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got read %h with no expected entry", dload2);
      end else begin
        chk("sb_dload", dload2, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst2 = 1'b0; rst_n = 1'b0;
    ren2 = 0; wen2 = 0; addr2 = 0; st2 = 0;
    ren0 = 0; wen0 = 0; addr0 = 0; st0 = 0;
    ren3 = 0; wen3 = 0; addr3 = 0; st3 = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state", {30'd0, ms2}, {30'd0, FR});
    chk("rst_dwait", {31'd0, dwait2}, 32'd1);
    chk("rst_dload", dload2, 32'd0);
    rst2 = 1'b1; rst_n = 1'b1;

    tbl.push_back(v(0,1,32'h10,DB,0,0,FR,1,0));
    tbl.push_back(v(0,1,32'h10,DB,0,0,BU,1,0));
    tbl.push_back(v(0,1,32'h10,DB,0,0,BU,1,0));
    tbl.push_back(v(0,1,32'h10,DB,0,0,AC,0,0));
    tbl.push_back(v(0,0,0,0,0,0,FR,1,0));
    tbl.push_back(v(1,0,32'h10,0,1,DB,FR,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,BU,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,BU,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,AC,0,DB));
    tbl.push_back(v(0,0,0,0,0,0,FR,1,DB));
    tbl.push_back(v(1,1,32'h20,A5,0,0,FR,1,DB));
    tbl.push_back(v(1,1,32'h20,A5,0,0,BU,1,DB));
    tbl.push_back(v(1,1,32'h20,A5,0,0,BU,1,DB));
    tbl.push_back(v(1,1,32'h20,A5,0,0,AC,0,DB));
    tbl.push_back(v(1,0,32'h20,0,1,A5,FR,1,DB));
    tbl.push_back(v(1,0,32'h20,0,0,0,BU,1,DB));
    tbl.push_back(v(1,0,32'h20,0,0,0,BU,1,DB));
    tbl.push_back(v(1,0,32'h20,0,0,0,AC,0,A5));
    tbl.push_back(v(1,0,32'h10,0,0,0,FR,1,A5));
    tbl.push_back(v(1,0,32'h10,0,0,0,BU,1,A5));
    tbl.push_back(v(1,0,32'h14,0,0,0,BU,1,A5));
    tbl.push_back(v(1,0,32'h14,0,1,0,FR,1,A5));
    tbl.push_back(v(1,0,32'h14,0,0,0,BU,1,A5));
    tbl.push_back(v(1,0,32'h14,0,0,0,BU,1,A5));
    tbl.push_back(v(1,0,32'h14,0,0,0,AC,0,0));
    tbl.push_back(v(0,1,32'h10,32'h1111_1111,0,0,FR,1,0));
    tbl.push_back(v(0,1,32'h10,32'h1111_1111,0,0,BU,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,BU,1,0));
    tbl.push_back(v(0,0,0,0,0,0,FR,1,0));
    tbl.push_back(v(1,0,32'h10,0,1,DB,FR,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,BU,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,BU,1,0));
    tbl.push_back(v(1,0,32'h10,0,0,0,AC,0,DB));
    tbl.push_back(v(0,0,0,0,0,0,FR,1,DB));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].push) sb.push_back(tbl[i].rd);
      drive2(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store);
      @(negedge CLK);
      chk($sformatf("tbl%0d_state", i), {30'd0, ms2}, {30'd0, tbl[i].st});
      chk($sformatf("tbl%0d_dwait", i), {31'd0, dwait2}, {31'd0, tbl[i].dw});
      chk($sformatf("tbl%0d_dload", i), dload2, tbl[i].dl);
    end

    // Reset pulse in the first BUSY cycle of a write to 0x8.
    drive2(0, 1, 32'h8, 32'hCAFE_F00D);
    drive2(0, 1, 32'h8, 32'hCAFE_F00D);
    @(negedge CLK);
    chk("rstmid_busy", {30'd0, ms2}, {30'd0, BU});
    rst2 = 1'b0;
    #1;
    chk("rstmid_dwait", {31'd0, dwait2}, 32'd1);
    chk("rstmid_dload", dload2, 32'd0);
    chk("rstmid_state", {30'd0, ms2}, {30'd0, FR});
    drive2(0, 0, 0, 0);
    rst2 = 1'b1;
    sb.push_back(32'd0);
    repeat (4) drive2(1, 0, 32'h8, 0);
    drive2(0, 0, 0, 0);
    sb.push_back(32'd0);
    repeat (4) drive2(1, 0, 32'h10, 0);
    drive2(0, 0, 0, 0);
    @(negedge CLK);
    chk("sb_drained", sb.size(), 32'd0);

    // LAT=0: write word 1, then read through an aliased address.
    @(posedge CLK); #1; wen0 = 1; addr0 = 32'h4; st0 = 32'h1234_5678;
    @(negedge CLK);
    chk("l0_w_c0_dwait", {31'd0, dwait0}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("l0_w_c1_dwait", {31'd0, dwait0}, 32'd0);
    chk("l0_w_c1_state", {30'd0, ms0}, {30'd0, AC});
    @(posedge CLK); #1; wen0 = 0; addr0 = 0; st0 = 0;
    @(negedge CLK);
    chk("l0_free", {30'd0, ms0}, {30'd0, FR});
    @(posedge CLK); #1; ren0 = 1; addr0 = 32'h404;
    @(negedge CLK);
    chk("l0_r_c0_dwait", {31'd0, dwait0}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("l0_r_c1_dwait", {31'd0, dwait0}, 32'd0);
    chk("l0_r_c1_dload", dload0, 32'h1234_5678);
    @(posedge CLK); #1; ren0 = 0; addr0 = 0;

    // LAT=3: read withdrawn in the second BUSY cycle.
    @(posedge CLK); #1; ren3 = 1; addr3 = 32'h40;
    @(negedge CLK);
    chk("l3_c0_state", {30'd0, ms3}, {30'd0, FR});
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("l3_c1_state", {30'd0, ms3}, {30'd0, BU});
    @(posedge CLK); #1; ren3 = 0;
    @(negedge CLK);
    chk("l3_c2_state", {30'd0, ms3}, {30'd0, BU});
    chk("l3_c2_dwait", {31'd0, dwait3}, 32'd1);
    for (int c = 3; c < 6; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk($sformatf("l3_c%0d_state", c), {30'd0, ms3}, {30'd0, FR});
      chk($sformatf("l3_c%0d_dwait", c), {31'd0, dwait3}, 32'd1);
      chk($sformatf("l3_c%0d_dload", c), dload3, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL accept parameter LAT, default 2, meaning wait-state cycles inserted before each access completes (legal range 0-15).
REQ-002 The block SHALL accept parameter DEPTH, default 256, meaning number of 32-bit words of backing storage (power of two).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 dREN  input  1  read request from the cache memory port, level-held until served.
REQ-007 dWEN  input  1  write request from the cache memory port, level-held until served.
REQ-008 daddr  input  32  byte address of the request.
REQ-009 dstore  input  32  write data, sampled in the ACCESS cycle.
REQ-010 dwait  output  1  high while the request is not complete; low for exactly the completion cycle.
REQ-011 dload  output  32  read data, valid in the cycle dwait is low for a read.
REQ-012 memstate  output  2  current state: 00 FREE, 01 BUSY, 10 ACCESS (11 unused).

Function
REQ-013 Word index SHALL be daddr[log2(DEPTH)+1:2]; daddr[1:0] ignored; upper bits ignored (address wraps modulo DEPTH words).
REQ-014 FREE: if dREN or dWEN high, latch index and type, load counter with LAT, go BUSY (LAT>0) or ACCESS (LAT=0); else stay FREE.
REQ-015 BUSY: counter decrements each cycle; when counter reaches 1 and request still present, go ACCESS next cycle.
REQ-016 ACCESS: lasts exactly one cycle; dwait low; write stores dstore at latched index; read drives dload from latched index; next state FREE unconditionally.
REQ-017 Latency from first cycle request seen in FREE to dwait-low cycle SHALL be LAT+1 cycles.
REQ-018 After ACCESS, block SHALL spend at least one cycle in FREE before accepting the next request (back-to-back request completes LAT+2 cycles after prior completion).
REQ-019 dWEN and dREN both high SHALL be treated as a write.
REQ-020 Request withdrawn (dREN and dWEN both low) in BUSY SHALL abort: return to FREE next cycle, no storage change.
REQ-021 daddr word index or request type changing while BUSY SHALL abort and return to FREE; the new request restarts the full latency from FREE.
REQ-022 dwait SHALL be high in FREE and BUSY regardless of request presence; dwait low only in ACCESS.
REQ-023 dload SHALL hold its last read value outside read ACCESS cycles; a write ACCESS SHALL not change dload.
REQ-024 A read of a word written by the immediately preceding access SHALL return the newly written data.

Reset
REQ-025 On nRST low, asynchronously: state FREE, memstate 00, dwait 1, dload 0, counter 0, all DEPTH storage words 0.
REQ-026 Reset asserted mid-BUSY or in ACCESS SHALL drop the request with no storage update; after release, block in FREE and a held request restarts full latency.

Verification
REQ-027 LAT=2: dWEN=1, daddr=0x0000_0010, dstore=0xDEAD_BEEF from cycle 0 -> dwait low only in cycle 3, memstate 00,01,01,10; then dREN same address -> dload=0xDEAD_BEEF in dwait-low cycle.
REQ-028 LAT=0: dREN at daddr=0x0000_0404 (DEPTH=256, aliases word 1) after write of 0x1234_5678 to 0x0000_0004 -> dwait low cycle 1, dload=0x1234_5678.
REQ-029 LAT=3: dREN held, dREN dropped in cycle 2 -> memstate 00 in cycle 3, dwait never low, dload unchanged.
REQ-030 dREN and dWEN both high, daddr=0x20, dstore=0xA5A5_A5A5 -> later read of 0x20 returns 0xA5A5_A5A5.
REQ-031 nRST pulsed low in cycle 1 of a write to 0x8 with LAT=2 -> dwait=1, dload=0 immediately; subsequent read of 0x8 returns 0x0000_0000.
REQ-032 daddr changed from 0x10 to 0x14 in BUSY -> FREE next cycle, then new read of 0x14 completes LAT+1 cycles after re-entry.
